// File: rtl/exc_err_ctrl_pkg.sv
// Shared constants, FSM state type and basic-op helpers for the excitation-error
// (taming) engine.
package exc_err_ctrl_pkg;

  localparam int L_SUBFR   = 40;
  localparam int L_INTER10 = 10;
  localparam logic [31:0] L_THRESH_ERR = 32'h3A98_0000;

  typedef enum logic [2:0] {StIdle, StZone, StScan, StFinish, StDone} state_e;

  // zone = number of zone boundaries at or below idx, which clamps to nz-1 naturally.
  function automatic int unsigned zone(input int idx, input int unsigned z0,
                                       input int unsigned zl, input int unsigned nz);
    int unsigned z;
    z = 0;
    for (int unsigned k = 1; k < nz; k++) begin
      if (idx >= int'(z0 + (k - 1) * zl)) z = k;
    end
    return z;
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (v < -64'sh0000_0000_8000_0000) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  // lo = (x >> 1) - (hi << 15) reduces to the low 15 bits of x above bit 0.
  function automatic void l_extract(input logic signed [31:0] x,
                                    output logic signed [15:0] hi,
                                    output logic signed [15:0] lo);
    hi = x[31:16];
    lo = {1'b0, x[15:1]};
  endfunction

endpackage

// File: rtl/exc_err_ctrl_if.sv
// Start/done command, result, history load and debug read bundle of exc_err_ctrl.
interface exc_err_ctrl_if #(
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned N_ZONES = 4
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  logic             start;
  logic             mode;
  logic [CH_W-1:0]  ch;
  logic [15:0]      t0;
  logic [15:0]      t0_frac;
  logic [15:0]      gain_pit;
  logic             busy;
  logic             done;
  logic             flag;
  logic [31:0]      max_out;
  logic             ld_en;
  logic [CH_W-1:0]  ld_ch;
  logic [IDX_W-1:0] ld_idx;
  logic [31:0]      ld_data;
  logic [CH_W-1:0]  rd_ch;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_data;

  modport master (
    output start, mode, ch, t0, t0_frac, gain_pit, ld_en, ld_ch, ld_idx, ld_data, rd_ch, rd_idx,
    input  busy, done, flag, max_out, rd_data
  );

  modport slave (
    input  start, mode, ch, t0, t0_frac, gain_pit, ld_en, ld_ch, ld_idx, ld_data, rd_ch, rd_idx,
    output busy, done, flag, max_out, rd_data
  );

endinterface

// File: rtl/exc_err_ctrl_f.sv
// Error-update function f(x, g) = L_add(L_shl(Mpy_32_16(L_Extract(x), g), 1), 0x4000),
// every stage saturating like the reference basic operators.
module exc_err_ctrl_f
  import exc_err_ctrl_pkg::*;
(
  input  logic signed [31:0] i_x,
  input  logic signed [15:0] i_gain,
  output logic signed [31:0] o_f
);

  logic signed [15:0] w_hi;
  logic signed [15:0] w_lo;
  logic signed [63:0] w_hi64;
  logic signed [63:0] w_lo64;
  logic signed [63:0] w_g64;
  logic signed [63:0] w_sum;
  logic signed [31:0] w_m;
  logic signed [63:0] w_m64;
  logic signed [31:0] w_s;
  logic signed [63:0] w_s64;

  always_comb begin
    l_extract(i_x, w_hi, w_lo);
    w_hi64 = w_hi;
    w_lo64 = w_lo;
    w_g64  = i_gain;
    w_sum  = 64'sd2 * w_hi64 * w_g64 + 64'sd2 * ((w_lo64 * w_g64) >>> 15);
    w_m    = sat32(w_sum);
    w_m64  = w_m;
    w_s    = sat32(w_m64 <<< 1);
    w_s64  = w_s;
    o_f    = sat32(w_s64 + 64'sd16384);
  end

endmodule

// File: rtl/exc_err_ctrl.sv
// Multi-channel test_err / update_exc_err engine with per-channel L_exc_err history
// held in registers; one history entry is visited per SCAN cycle.
module exc_err_ctrl
  import exc_err_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned N_ZONES   = 4,
  parameter int unsigned ZONE0_LEN = 38,
  parameter int unsigned ZONE_LEN  = 40,
  parameter logic [31:0] THRESH    = L_THRESH_ERR,
  parameter logic [31:0] INIT_VAL  = 32'h0000_4000
) (
  input logic           i_clk,
  input logic           i_rst,
  exc_err_ctrl_if.slave io_bus
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  state_e             r_state;
  logic               r_mode;
  logic [CH_W-1:0]    r_ch;
  logic signed [15:0] r_t0;
  logic signed [15:0] r_frac;
  logic signed [15:0] r_gain;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_end;
  logic               r_down;
  logic               r_neg;
  logic               r_pass2;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_fprev;
  logic               r_busy;
  logic               r_done;
  logic               r_flag;
  logic [31:0]        r_max;
  logic [31:0]        r_hist [NUM_CH][N_ZONES];

  int                 w_t1;
  int                 w_n;
  int                 w_lag_lo;
  logic [IDX_W-1:0]   w_z1;
  logic [IDX_W-1:0]   w_z2;
  logic [IDX_W-1:0]   w_zn;
  logic [IDX_W-1:0]   w_zt;
  logic signed [31:0] w_x;
  logic signed [31:0] w_f;
  logic signed [31:0] w_val;
  logic               w_last;
  logic               w_ld_ok;

  exc_err_ctrl_f u_f (
    .i_x    (w_x),
    .i_gain (r_gain),
    .o_f    (w_f)
  );

  always_comb begin
    w_t1     = int'(r_t0) + ((r_frac > 16'sd0) ? 1 : 0);
    w_n      = int'(r_t0) - L_SUBFR;
    w_lag_lo = w_t1 - (L_SUBFR + L_INTER10);
    if (w_lag_lo < 0) w_lag_lo = 0;
    w_z1 = IDX_W'(zone(w_lag_lo, ZONE0_LEN, ZONE_LEN, N_ZONES));
    w_z2 = IDX_W'(zone(w_t1 + L_INTER10 - 2, ZONE0_LEN, ZONE_LEN, N_ZONES));
    w_zn = IDX_W'(zone(w_n, ZONE0_LEN, ZONE_LEN, N_ZONES));
    w_zt = IDX_W'(zone(int'(r_t0) - 1, ZONE0_LEN, ZONE_LEN, N_ZONES));
    // Short-lag update feeds f its own first result on the second pass.
    w_x     = (r_neg && r_pass2) ? r_fprev : r_hist[r_ch][r_idx];
    w_val   = r_mode ? w_f : w_x;
    w_last  = (r_idx == r_end) && !(r_neg && !r_pass2);
    w_ld_ok = io_bus.ld_en && (!r_busy || (io_bus.ld_ch != r_ch));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_mode  <= 1'b0;
      r_ch    <= '0;
      r_t0    <= '0;
      r_frac  <= '0;
      r_gain  <= '0;
      r_idx   <= '0;
      r_end   <= '0;
      r_down  <= 1'b0;
      r_neg   <= 1'b0;
      r_pass2 <= 1'b0;
      r_acc   <= '0;
      r_fprev <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_max   <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        for (int z = 0; z < int'(N_ZONES); z++) r_hist[CH_W'(c)][IDX_W'(z)] <= INIT_VAL;
      end
    end else begin
      r_done <= 1'b0;
      if (w_ld_ok) r_hist[io_bus.ld_ch][io_bus.ld_idx] <= io_bus.ld_data;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_mode  <= io_bus.mode;
            r_ch    <= io_bus.ch;
            r_t0    <= io_bus.t0;
            r_frac  <= io_bus.t0_frac;
            r_gain  <= io_bus.gain_pit;
            r_busy  <= 1'b1;
            r_state <= StZone;
          end
        end
        StZone: begin
          r_acc   <= '1;
          r_pass2 <= 1'b0;
          if (!r_mode) begin
            r_idx  <= w_z2;
            r_end  <= w_z1;
            r_down <= 1'b1;
            r_neg  <= 1'b0;
          end else if (w_n < 0) begin
            r_idx  <= '0;
            r_end  <= '0;
            r_down <= 1'b0;
            r_neg  <= 1'b1;
          end else begin
            r_idx  <= w_zn;
            r_end  <= w_zt;
            r_down <= 1'b0;
            r_neg  <= 1'b0;
          end
          r_state <= StScan;
        end
        StScan: begin
          if (w_val > r_acc) r_acc <= w_val;
          r_fprev <= w_f;
          if (w_last) r_state <= StFinish;
          else if (r_neg) r_pass2 <= 1'b1;
          else if (r_down) r_idx <= r_idx - 1'b1;
          else r_idx <= r_idx + 1'b1;
        end
        StFinish: begin
          r_max <= r_acc;
          if (!r_mode) begin
            r_flag <= (r_acc > $signed(THRESH));
          end else begin
            // Written after the load strobe so the commit overrides a same-word load.
            for (int k = int'(N_ZONES) - 1; k > 0; k--) begin
              r_hist[r_ch][IDX_W'(k)] <= r_hist[r_ch][IDX_W'(k - 1)];
            end
            r_hist[r_ch][0] <= r_acc;
          end
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.flag    = r_flag;
  assign io_bus.max_out = r_max;
  assign io_bus.rd_data = r_hist[io_bus.rd_ch][io_bus.rd_idx];

endmodule

// File: tb/tb_exc_err_ctrl.sv
// Randomized and directed bench for exc_err_ctrl against a lag/zone reference model.
module tb_exc_err_ctrl;

  localparam int NCH = 2;
  localparam int NZ  = 4;
  localparam int THR = 983040000;
  localparam int INIT = 32'h4000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   m_hist [NCH][NZ];

  exc_err_ctrl_if #(.NUM_CH(NCH), .N_ZONES(NZ)) bus ();

  exc_err_ctrl #(.NUM_CH(NCH), .N_ZONES(NZ)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int m_sat(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return int'(32'h8000_0000);
    return int'(v);
  endfunction

  function automatic int m_zone(input int idx);
    int z;
    if (idx < 38) return 0;
    z = 1 + (idx - 38) / 40;
    return (z > NZ - 1) ? NZ - 1 : z;
  endfunction

  function automatic int m_f(input int x, input int g);
    longint hi, lo, m;
    hi = longint'(x >>> 16);
    lo = longint'(x >>> 1) - hi * 32768;
    m  = m_sat(2 * hi * g + 2 * ((lo * g) >>> 15));
    m  = m_sat(2 * m);
    return m_sat(m + 16384);
  endfunction

  task automatic model_op(input bit mode, input int ch, input int t0, input int frac,
                          input int g, output int mx, output bit fl);
    int t1, lo, n, a, b;
    mx = -1;
    fl = 1'b0;
    if (!mode) begin
      t1 = t0 + ((frac > 0) ? 1 : 0);
      lo = (t1 - 50 > 0) ? t1 - 50 : 0;
      for (int i = m_zone(lo); i <= m_zone(t1 + 8); i++) if (m_hist[ch][i] > mx) mx = m_hist[ch][i];
      fl = (mx > THR);
    end else begin
      n = t0 - 40;
      if (n < 0) begin
        a = m_f(m_hist[ch][0], g);
        b = m_f(a, g);
        if (a > mx) mx = a;
        if (b > mx) mx = b;
      end else begin
        for (int i = m_zone(n); i <= m_zone(t0 - 1); i++) begin
          a = m_f(m_hist[ch][i], g);
          if (a > mx) mx = a;
        end
      end
      for (int k = NZ - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k - 1];
      m_hist[ch][0] = mx;
    end
  endtask

  task automatic load(input int ch, input int idx, input int data);
    @(negedge clk);
    bus.ld_en   = 1'b1;
    bus.ld_ch   = 1'(ch);
    bus.ld_idx  = 2'(idx);
    bus.ld_data = data;
    @(negedge clk);
    bus.ld_en = 1'b0;
    m_hist[ch][idx] = data;
  endtask

  task automatic check_hist(input int ch);
    for (int i = 0; i < NZ; i++) begin
      bus.rd_ch  = 1'(ch);
      bus.rd_idx = 2'(i);
      #1;
      check_val("history", bus.rd_data, m_hist[ch][i]);
    end
  endtask

  task automatic start_op(input bit mode, input int ch, input int t0, input int frac,
                          input int g);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = mode;
    bus.ch       = 1'(ch);
    bus.t0       = 16'(t0);
    bus.t0_frac  = 16'(frac);
    bus.gain_pit = 16'(g);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("done_seen", bus.done, 1);
    check_val("latency_bound", (lat <= NZ + 3), 1);
  endtask

  task automatic run_op(input bit mode, input int ch, input int t0, input int frac,
                        input int g, output int mx, output bit fl);
    int emx, lat;
    bit efl;
    model_op(mode, ch, t0, frac, g, emx, efl);
    start_op(mode, ch, t0, frac, g);
    check_val("busy_after_start", bus.busy, 1);
    wait_done(1, lat);
    mx = bus.max_out;
    fl = bus.flag;
    check_val("max_out", mx, emx);
    if (!mode) check_val("flag", fl, efl);
    @(negedge clk);
    check_val("done_single_cycle", bus.done, 0);
    check_hist(ch);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) for (int i = 0; i < NZ; i++) m_hist[c][i] = INIT;
    check_val("reset_busy", bus.busy, 0);
    check_val("reset_done", bus.done, 0);
    check_val("reset_flag", bus.flag, 0);
    check_val("reset_max", bus.max_out, 0);
    for (int c = 0; c < NCH; c++) check_hist(c);
  endtask

  function automatic int rand_word();
    case ($urandom_range(0, 5))
      0: return int'($urandom);
      1: return THR + int'($urandom_range(0, 4)) - 2;
      2: return int'($urandom_range(0, 70000));
      3: return 32'h7FFF_FFFF;
      4: return int'(32'h8000_0000) + int'($urandom_range(0, 15));
      default: return -int'($urandom_range(1, 100000));
    endcase
  endfunction

  initial begin
    int  mx, emx, lat, t0, frac, g, ch;
    bit  fl, efl, mode;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.ch = '0; bus.t0 = '0; bus.t0_frac = '0;
    bus.gain_pit = '0; bus.ld_en = 1'b0; bus.ld_ch = '0; bus.ld_idx = '0; bus.ld_data = '0;
    bus.rd_ch = '0; bus.rd_idx = '0;
    do_reset();

    // Directed cases around the threshold and zone boundaries.
    load(0, 0, 32'h3A98_0001); load(0, 1, 0); load(0, 2, 0); load(0, 3, 0);
    run_op(1'b0, 0, 60, 0, 0, mx, fl);
    check_val("t1_flag", fl, 1);
    check_val("t1_max", mx, 32'h3A98_0001);
    load(0, 0, 32'h3A98_0000);
    run_op(1'b0, 0, 60, 0, 0, mx, fl);
    check_val("t2_flag", fl, 0);
    check_val("t2_max", mx, 32'h3A98_0000);
    load(0, 0, 32'h3FFF_FFFF); load(0, 3, 32'h10);
    run_op(1'b0, 0, 143, 1, 0, mx, fl);
    check_val("t3_flag", fl, 0);
    check_val("t3_max", mx, 32'h10);

    do_reset();
    run_op(1'b1, 0, 30, 0, 32'h4000, mx, fl);
    check_val("t4_worst", mx, 32'h0000_C000);
    bus.rd_ch = 1'b0; bus.rd_idx = 2'd0; #1;
    check_val("t4_hist0", bus.rd_data, 32'h0000_C000);
    bus.rd_idx = 2'd3; #1;
    check_val("t4_hist3", bus.rd_data, 32'h0000_4000);

    for (int i = 0; i < NZ; i++) load(0, i, 32'h7FFF_FFFF);
    run_op(1'b1, 0, 60, 0, 32'h7FFF, mx, fl);
    check_val("t5_sat", mx, 32'h7FFF_FFFF);

    for (int it = 0; it < 60; it++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int j = 0; j < nl; j++) load($urandom_range(0, 1), $urandom_range(0, 3), rand_word());
      mode = 1'($urandom_range(0, 1));
      ch   = $urandom_range(0, 1);
      t0   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 400) : $urandom_range(20, 143);
      frac = int'($urandom_range(0, 2)) - 1;
      g    = int'($urandom_range(0, 65535)) - 32768;
      run_op(mode, ch, t0, frac, g, mx, fl);
    end

    // Cross-channel load and a start while busy; the same-channel load must be dropped.
    model_op(1'b1, 1, 100, 0, 32'h2000, emx, efl);
    start_op(1'b1, 1, 100, 0, 32'h2000);
    bus.start = 1'b1; bus.mode = 1'b0; bus.ch = 1'b0;
    bus.ld_en = 1'b1; bus.ld_ch = 1'b0; bus.ld_idx = 2'd2; bus.ld_data = 32'h1234_5678;
    m_hist[0][2] = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ld_ch = 1'b1; bus.ld_idx = 2'd0; bus.ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ld_en = 1'b0;
    wait_done(3, lat);
    check_val("t6_worst", bus.max_out, emx);
    @(negedge clk);
    check_hist(0);
    check_hist(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("t6_no_extra_done", bus.done, 0);
      check_val("t6_no_extra_busy", bus.busy, 0);
    end

    // Reset in the middle of a scan aborts without a done pulse.
    start_op(1'b1, 0, 143, 0, 32'h3000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_rst_busy", bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      check_val("t6_rst_no_done", bus.done, 0);
    end
    for (int c = 0; c < NCH; c++) for (int i = 0; i < NZ; i++) m_hist[c][i] = INIT;
    check_hist(0);
    check_hist(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
